// File: rtl/node_port_arbiter_if.sv
// Handshake and strobe bundle between the three instruction sources, the arbiter
// and the node controller.
interface node_port_arbiter_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = 16
);
    logic                 cs_left;
    logic                 cs_right;
    logic                 cs_self;
    logic [WIDTH-1:0]     data_left;
    logic [WIDTH-1:0]     data_right;
    logic [WIDTH-1:0]     data_self;
    logic                 out_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [1:0]           out_src;
    logic                 drop_left;
    logic                 drop_right;
    logic                 drop_self;
    logic [2:0]           pending;
    logic [CNT_WIDTH-1:0] fwd_count;

    // Environment side: sources and the node controller.
    modport master (
        output cs_left, cs_right, cs_self, data_left, data_right, data_self, out_ready,
        input  out_valid, out_data, out_src, drop_left, drop_right, drop_self, pending,
               fwd_count
    );

    // Arbiter side.
    modport slave (
        input  cs_left, cs_right, cs_self, data_left, data_right, data_self, out_ready,
        output out_valid, out_data, out_src, drop_left, drop_right, drop_self, pending,
               fwd_count
    );
endinterface

// File: rtl/node_port_arbiter.sv
// Buffered round-robin arbiter for the left, right and self instruction sources of
// a 1-D interconnect node; one instruction at a time over valid/ready.
module node_port_arbiter #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned CNT_WIDTH = 16
) (
    input logic               clk,
    input logic               reset_n,
    node_port_arbiter_if.slave bus
);
    localparam int unsigned AddrWidth = $clog2(DEPTH);
    localparam int unsigned PtrWidth  = AddrWidth + 1;

    // Port index 0 = left, 1 = right, 2 = self; source tag is index + 1.
    logic [2:0]           csVec;
    logic [WIDTH-1:0]     dataIn [3];
    logic [WIDTH-1:0]     mem [3][DEPTH];
    logic [PtrWidth-1:0]  wrPtr [3];
    logic [PtrWidth-1:0]  rdPtr [3];
    logic [2:0]           notEmpty;
    logic [2:0]           isFull;
    logic [2:0]           push;
    logic [2:0]           pop;
    logic [2:0]           dropQ;

    logic [1:0]           lastGrant;
    logic                 outValidQ;
    logic [WIDTH-1:0]     outDataQ;
    logic [1:0]           outSrcQ;
    logic [CNT_WIDTH-1:0] fwdCountQ;

    logic                 loadEn;
    logic                 grantValid;
    logic [1:0]           grantIdx;
    logic [1:0]           cand;
    logic [WIDTH-1:0]     headData;

    assign csVec     = {bus.cs_self, bus.cs_right, bus.cs_left};
    assign dataIn[0] = bus.data_left;
    assign dataIn[1] = bus.data_right;
    assign dataIn[2] = bus.data_self;

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            notEmpty[p] = wrPtr[p] != rdPtr[p];
            isFull[p]   = (wrPtr[p][AddrWidth] != rdPtr[p][AddrWidth]) &&
                          (wrPtr[p][AddrWidth-1:0] == rdPtr[p][AddrWidth-1:0]);
            // A full FIFO still takes a push when its head leaves in the same cycle.
            push[p]     = csVec[p] && (!isFull[p] || pop[p]);
        end
    end

    assign loadEn = !outValidQ || bus.out_ready;

    // Search starts one past the last grant and wraps left -> right -> self.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = lastGrant;
        cand       = lastGrant;
        for (int k = 0; k < 3; k++) begin
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
            if (!grantValid && notEmpty[cand]) begin
                grantValid = 1'b1;
                grantIdx   = cand;
            end
        end
    end

    always_comb begin
        pop = 3'b000;
        if (loadEn && grantValid) begin
            pop = 3'b001 << grantIdx;
        end
    end

    assign headData = mem[grantIdx][rdPtr[grantIdx][AddrWidth-1:0]];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int p = 0; p < 3; p++) begin
                wrPtr[p] <= '0;
                rdPtr[p] <= '0;
            end
            dropQ <= 3'b000;
        end else begin
            for (int p = 0; p < 3; p++) begin
                if (push[p]) begin
                    mem[p][wrPtr[p][AddrWidth-1:0]] <= dataIn[p];
                    wrPtr[p] <= wrPtr[p] + 1'b1;
                end
                if (pop[p]) begin
                    rdPtr[p] <= rdPtr[p] + 1'b1;
                end
                dropQ[p] <= csVec[p] && isFull[p] && !pop[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            outValidQ <= 1'b0;
            outDataQ  <= '0;
            outSrcQ   <= 2'b00;
            lastGrant <= 2'd2;
            fwdCountQ <= '0;
        end else begin
            if (outValidQ && bus.out_ready) begin
                fwdCountQ <= fwdCountQ + 1'b1;
            end
            if (loadEn) begin
                if (grantValid) begin
                    outValidQ <= 1'b1;
                    outDataQ  <= headData;
                    outSrcQ   <= grantIdx + 2'd1;
                    lastGrant <= grantIdx;
                end else begin
                    // Idle: data keeps its last value, only valid and tag clear.
                    outValidQ <= 1'b0;
                    outSrcQ   <= 2'b00;
                end
            end
        end
    end

    assign bus.out_valid  = outValidQ;
    assign bus.out_data   = outDataQ;
    assign bus.out_src    = outSrcQ;
    assign bus.drop_left  = dropQ[0];
    assign bus.drop_right = dropQ[1];
    assign bus.drop_self  = dropQ[2];
    assign bus.pending    = notEmpty;
    assign bus.fwd_count  = fwdCountQ;
endmodule

// File: doc/node_port_arbiter.md
Name: node_port_arbiter

Overview:
- Round-robin arbiter with buffering for a 1-D interconnect node's three instruction sources: left neighbour, right neighbour, local self.
- Sits between the per-port shift-in interfaces and the node controller. Replaces fixed-priority selection with fair, buffered arbitration.
- Drives one instruction at a time, with a source tag, over a valid/ready handshake. Reports overflow drops.

Parameters:
WIDTH, 32, instruction width in bits
DEPTH, 2, entries per per-port FIFO; must be a power of two, at least 2
CNT_WIDTH, 16, width of forwarded-instruction counter

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset, sampled on rising clk
cs_left  input  1  one-cycle strobe: data_left valid this cycle
cs_right  input  1  one-cycle strobe: data_right valid this cycle
cs_self  input  1  one-cycle strobe: data_self valid this cycle
data_left  input  WIDTH  instruction from left neighbour
data_right  input  WIDTH  instruction from right neighbour
data_self  input  WIDTH  instruction from local source
out_ready  input  1  node controller accepts out_data this cycle
out_valid  output  1  out_data/out_src hold a valid instruction
out_data  output  WIDTH  selected instruction
out_src  output  2  source tag: 2'b01 left, 2'b10 right, 2'b11 self, 2'b00 when idle
drop_left  output  1  one-cycle pulse: left strobe discarded, FIFO full
drop_right  output  1  one-cycle pulse: right strobe discarded, FIFO full
drop_self  output  1  one-cycle pulse: self strobe discarded, FIFO full
pending  output  3  {self,right,left} FIFO non-empty flags, registered
fwd_count  output  CNT_WIDTH  count of handshakes completed (out_valid and out_ready)

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - All FIFOs empty.
  - out_valid=0, out_data=0, out_src=00.
  - drop_*=0, pending=000, fwd_count=0.
  - Last-grant pointer = self, so left has first priority.
  - Reset mid-operation discards all buffered and presented data; strobes in the reset cycle are ignored.
- Enqueue:
  - cs_x=1 at an edge writes data_x into FIFO x if it is not full.
  - If FIFO x is full and is not popped that same cycle, the word is discarded and drop_x=1 for the next cycle only.
  - Full FIFO with a simultaneous pop accepts the push.
  - All three ports may enqueue in the same cycle.
- Output register load condition: load_en = (out_valid==0) or out_ready.
- Arbitration, when load_en=1:
  - Search order starts after the last grant, cycling left -> right -> self -> left.
  - The first non-empty FIFO is popped into out_data/out_src; out_valid=1.
  - The last-grant pointer updates to that port.
  - If no FIFO is non-empty: out_valid=0, out_src=00, out_data holds its old value.
- Arbitration sees FIFO state before this edge's pushes. Minimum latency from strobe to out_valid is 2 edges: push at edge N, load at edge N+1.
- Handshake:
  - out_data/out_src stay stable while out_valid=1 and out_ready=0.
  - One instruction transfers per cycle with out_valid and out_ready high.
  - Back-to-back transfers give full throughput.
- pending reflects FIFO occupancy after each edge.
- fwd_count increments by 1 on each completed handshake and wraps from all-ones to 0.
- FIFO pointers are log2(DEPTH)+1 bits; full/empty come from the MSB compare and wrap naturally.

Test Plan:
- Reset, then cs_left with data_left=32'hA000_0001 -> out_valid=1 two edges later, out_data=A0000001, out_src=01; out_ready=1 -> fwd_count=1, out_valid=0 next cycle.
- cs_left, cs_right and cs_self in the same cycle (data 11,22,33), out_ready held 1 -> outputs in order 11/01, 22/10, 33/11 on consecutive cycles, pending falls 111 -> 110 -> 100 -> 000.
- Fairness: left and self each strobed every cycle for 8 cycles, out_ready=1 -> grants alternate left/self, no port granted twice in a row while the other is pending.
- Overflow: out_ready=0, cs_right strobed 4 times (data 1..4), DEPTH=2 -> drop_right pulses on the 4th strobe only; after out_ready=1 outputs are 1,2,3 (one sits in the output register); 4 is lost.
- Stall hold: out_valid=1 with out_ready=0 for 5 cycles while new strobes arrive -> out_data/out_src unchanged; then released in round-robin order.
- Reset asserted with 2 entries buffered and out_valid=1 -> next cycle out_valid=0, pending=000, fwd_count=0; a subsequent cs_right is granted first only if left and self are empty; left wins a tie.
